// File: rtl/performance_counter_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types: shared LC-3b types for the performance counter.
//   lc3b_word   - 16-bit machine word
//   lc3b_opcode - the 16 LC-3b opcodes (instruction bits [15:12])
//   perf_mode_t - counter_type mode select
// Helper functions classify opcodes into the memory and control groups.
// -----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    PERF_ALL     = 2'd0,
    PERF_BRANCH  = 2'd1,
    PERF_MEMORY  = 2'd2,
    PERF_CONTROL = 2'd3
  } perf_mode_t;

  function automatic logic is_load(input lc3b_opcode op);
    return (op == op_ldb) || (op == op_ldr) || (op == op_ldi);
  endfunction

  function automatic logic is_store(input lc3b_opcode op);
    return (op == op_stb) || (op == op_str) || (op == op_sti);
  endfunction

  function automatic logic is_control(input lc3b_opcode op);
    return (op == op_jsr) || (op == op_jmp) || (op == op_trap) || (op == op_rti);
  endfunction

endpackage

// File: rtl/performance_counter_event_counter.sv
// -----------------------------------------------------------------------------
// perf_event_counter: 16-bit event counter with synchronous clear.
//   clk   - clock
//   rst_n - asynchronous active-low reset (count -> 0)
//   inc   - add one this edge
//   clr   - clear to zero this edge (wins over inc)
//   count - registered count
// Macro PERF_COUNTER_SATURATE_EN: defined -> hold at 0xFFFF; undefined -> wrap.
// -----------------------------------------------------------------------------
module perf_event_counter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc,
  input  logic     clr,
  output lc3b_word count
);

  lc3b_word count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
`ifdef PERF_COUNTER_SATURATE_EN
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`else
      count_d = count_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/performance_counter.sv
// -----------------------------------------------------------------------------
// performance_counter: LC-3b retirement-event monitor.
//   clk          - clock
//   rst_n        - asynchronous active-low reset
//   trigger      - one-cycle strobe per instruction event
//   pc_in        - PC of the triggering instruction
//   opcode       - opcode of the triggering instruction
//   counter_type - mode: 0 ALL, 1 BRANCH, 2 MEMORY, 3 CONTROL
//   count1       - primary count (registered)
//   count2       - secondary count (registered)
// Overflow behaviour follows macro PERF_COUNTER_SATURATE_EN (see
// perf_event_counter): saturate when defined, wrap otherwise.
// -----------------------------------------------------------------------------
module performance_counter
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  lc3b_word   pc_in,
  input  lc3b_opcode opcode,
  input  logic [1:0] counter_type,
  output lc3b_word   count1,
  output lc3b_word   count2
);

  perf_mode_t mode_q, mode_d;
  logic       pend_q, pend_d;
  lc3b_word   br_pc_q, br_pc_d;

  logic inc1, inc2, clr;
  perf_mode_t req_mode;

  assign req_mode = perf_mode_t'(counter_type);

  always_comb begin
    mode_d  = mode_q;
    pend_d  = pend_q;
    br_pc_d = br_pc_q;
    inc1    = 1'b0;
    inc2    = 1'b0;
    clr     = 1'b0;

    if (req_mode != mode_q) begin
      // Mode switch edge: wipe everything and count nothing.
      mode_d = req_mode;
      pend_d = 1'b0;
      clr    = 1'b1;
    end else begin
      unique case (mode_q)
        PERF_ALL: begin
          inc1 = trigger;
          inc2 = 1'b1;
        end
        PERF_BRANCH: begin
          if (trigger) begin
            // Resolve any pending BR before possibly recording this one,
            // so back-to-back BRs are each classified.
            if (pend_q && (pc_in != br_pc_q + 16'd2)) inc2 = 1'b1;
            pend_d = (opcode == op_br);
            inc1   = (opcode == op_br);
            if (opcode == op_br) br_pc_d = pc_in;
          end
        end
        PERF_MEMORY: begin
          inc1 = trigger && is_load(opcode);
          inc2 = trigger && is_store(opcode);
        end
        PERF_CONTROL: begin
          inc1 = trigger && is_control(opcode);
          inc2 = !trigger;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= PERF_ALL;
      pend_q  <= 1'b0;
      br_pc_q <= '0;
    end else begin
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      br_pc_q <= br_pc_d;
    end
  end

  perf_event_counter u_cnt1 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc1),
    .clr   (clr),
    .count (count1)
  );

  perf_event_counter u_cnt2 (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc2),
    .clr   (clr),
    .count (count2)
  );

endmodule

// File: tb/tb_performance_counter.sv
module tb_performance_counter;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger;
  lc3b_word   pc_in;
  lc3b_opcode opcode;
  logic [1:0] counter_type;
  lc3b_word   count1, count2;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_c1, m_c2, m_mode, m_brpc;
  bit m_pend;

  performance_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .pc_in        (pc_in),
    .opcode       (opcode),
    .counter_type (counter_type),
    .count1       (count1),
    .count2       (count2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bump(input int c);
`ifdef PERF_COUNTER_SATURATE_EN
    return (c >= 65535) ? 65535 : c + 1;
`else
    return (c + 1) % 65536;
`endif
  endfunction

  task automatic model_reset();
    m_c1 = 0; m_c2 = 0; m_mode = 0; m_brpc = 0; m_pend = 0;
  endtask

  task automatic model_edge(input bit trig, input int pc, input int op, input int ct);
    if (ct != m_mode) begin
      m_c1 = 0; m_c2 = 0; m_pend = 0; m_mode = ct;
      return;
    end
    case (m_mode)
      0: begin
        if (trig) m_c1 = bump(m_c1);
        m_c2 = bump(m_c2);
      end
      1: if (trig) begin
        if (m_pend && pc != ((m_brpc + 2) % 65536)) m_c2 = bump(m_c2);
        if (op == 0) begin
          m_c1 = bump(m_c1);
          m_brpc = pc;
          m_pend = 1;
        end else begin
          m_pend = 0;
        end
      end
      2: if (trig) begin
        if (op inside {2, 6, 10}) m_c1 = bump(m_c1);
        if (op inside {3, 7, 11}) m_c2 = bump(m_c2);
      end
      default: begin
        if (trig && (op inside {4, 12, 15, 8})) m_c1 = bump(m_c1);
        if (!trig) m_c2 = bump(m_c2);
      end
    endcase
  endtask

  // Drive inputs (from just after a negedge), clock one edge, update model,
  // and optionally compare at the following negedge.
  task automatic cycle(input bit trig, input int pc, input int op, input int ct,
                       input bit chk, input string tag);
    trigger      = trig;
    pc_in        = pc[15:0];
    opcode       = lc3b_opcode'(op[3:0]);
    counter_type = ct[1:0];
    @(posedge clk);
    model_edge(trig, pc, op, ct);
    @(negedge clk);
    if (chk) begin
      check_eq({tag, ".c1"}, int'(count1), m_c1);
      check_eq({tag, ".c2"}, int'(count2), m_c2);
    end
  endtask

  initial begin
    int ct;
    int pc;
    int op;
    int sat_exp;
    rst_n = 1'b0; trigger = 1'b0; pc_in = '0; opcode = op_br; counter_type = 2'd0;
    model_reset();
    #12;
    check_eq("rst.c1", int'(count1), 0);
    check_eq("rst.c2", int'(count2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mode 0: trigger 0,1,0,1,0
    cycle(0, 0, 1, 0, 1, "all0");
    cycle(1, 0, 1, 0, 1, "all1");
    cycle(0, 0, 1, 0, 1, "all2");
    cycle(1, 0, 1, 0, 1, "all3");
    cycle(0, 0, 1, 0, 1, "all4");
    check_eq("all.c1", int'(count1), 2);
    check_eq("all.c2", int'(count2), 5);

    // Mode 1
    cycle(0, 0, 1, 1, 1, "sw1");
    cycle(1, 'h3000, 0, 1, 1, "br0");
    cycle(1, 'h3002, 1, 1, 1, "br1");
    check_eq("brnt.c1", int'(count1), 1);
    check_eq("brnt.c2", int'(count2), 0);
    cycle(1, 'h3004, 0, 1, 1, "br2");
    cycle(0, 'h1234, 0, 1, 1, "br3");
    cycle(1, 'h3100, 1, 1, 1, "br4");
    check_eq("brt.c1", int'(count1), 2);
    check_eq("brt.c2", int'(count2), 1);
    // back-to-back BRs, then wrap-around PC target
    cycle(1, 'hFFFE, 0, 1, 1, "br5");
    cycle(1, 'h0000, 0, 1, 1, "br6");
    cycle(1, 'h0010, 1, 1, 1, "br7");

    // Mode 2
    cycle(0, 0, 1, 2, 1, "sw2");
    cycle(1, 0, 6, 2, 1, "mem0");
    cycle(1, 0, 3, 2, 1, "mem1");
    cycle(1, 0, 1, 2, 1, "mem2");
    cycle(1, 0, 10, 2, 1, "mem3");
    check_eq("mem.c1", int'(count1), 2);
    check_eq("mem.c2", int'(count2), 1);

    // Mode 0 three events, then switch to mode 3 with a trigger present
    cycle(0, 0, 1, 0, 1, "sw0");
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 1, "ev");
    cycle(1, 0, 4, 3, 1, "sw3");
    check_eq("sw3.c1", int'(count1), 0);
    check_eq("sw3.c2", int'(count2), 0);
    cycle(1, 0, 15, 3, 1, "ctl0");
    cycle(0, 0, 15, 3, 1, "ctl1");
    cycle(1, 0, 5, 3, 1, "ctl2");

    // Randomized traffic
    ct = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) ct = $urandom_range(0, 3);
      op = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
      pc = (m_pend && $urandom_range(0, 1) == 1) ? (m_brpc + 2) % 65536
                                                 : $urandom_range(0, 65535);
      cycle($urandom_range(0, 2) != 0, pc, op, ct, 1, "rnd");
    end

    // Asynchronous reset mid-count, between edges (set up a pending BR first)
    cycle(0, 0, 1, 1, 1, "pre_sw");
    cycle(1, 'h4000, 0, 1, 1, "pre_br");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("arst.c1", int'(count1), 0);
    check_eq("arst.c2", int'(count2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 1, 0, 1, "post_rst");

    // Overflow: preload counter 1 to 0xFFFF in mode 0, then one more trigger
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) cycle(1, 0, 1, 0, 0, "pre");
    check_eq("pre.c1", int'(count1), 'hFFFF);
    cycle(1, 0, 1, 0, 1, "ovf");
`ifdef PERF_COUNTER_SATURATE_EN
    sat_exp = 'hFFFF;
`else
    sat_exp = 0;
`endif
    check_eq("ovf.const", int'(count1), sat_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
